// File: rtl/vx_run_ctrl.sv
// APB-programmed run controller: sequences core reset/clock-enable, relocates core AXI addresses
// by BASE, flags out-of-window accesses and counts run cycles.
module vx_run_ctrl #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int RESET_DELAY    = 8,
    parameter int BUSY_GRACE     = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [31:0]               paddr,
    input  logic [31:0]               pwdata,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    input  logic                      core_busy,
    output logic                      core_clk_en,
    output logic                      core_reset,
    input  logic [AXI_ADDR_WIDTH-1:0] raw_araddr,
    input  logic [AXI_ADDR_WIDTH-1:0] raw_awaddr,
    input  logic                      raw_arvalid,
    input  logic                      raw_awvalid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                      irq
);

    // state | meaning
    // IDLE  | core held in reset, clock gated
    // RESET | clock running, core reset asserted for RESET_DELAY cycles
    // RUN   | core released; counting cycles, waiting for busy to drop
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [7:0]  OFF_BASE   = 8'h50;
    localparam logic [7:0]  OFF_CTRL   = 8'h54;
    localparam logic [7:0]  OFF_STATUS = 8'h58;
    localparam logic [7:0]  OFF_CYCLES = 8'h5C;
    localparam logic [7:0]  OFF_WINDOW = 8'h60;
    localparam logic [31:0] RD_LAST    = 32'(RESET_DELAY - 1);
    localparam logic [31:0] GRACE      = 32'(BUSY_GRACE);

    state_e                    state_q, state_d;
    logic [31:0]               ctr_q, ctr_d;
    logic [CNT_WIDTH-1:0]      cycles_q, cycles_d;
    logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
    logic [AXI_ADDR_WIDTH-1:0] window_q, window_d;
    logic                      irq_en_q, irq_en_d;
    logic                      done_q, done_d;
    logic                      addr_err_q, addr_err_d;

    logic [7:0]  offset;
    logic        mapped, wr_en;
    logic        wr_base, wr_ctrl, wr_status, wr_window;
    logic        start_req, abort_req, window_hit;
    logic [31:0] rd_data, base_rd, window_rd, cycles_rd;
    logic        unused_paddr_hi;

    assign offset          = paddr[7:0];
    assign unused_paddr_hi = ^paddr[31:8];
    assign mapped = (offset == OFF_BASE) || (offset == OFF_CTRL) || (offset == OFF_STATUS) ||
                    (offset == OFF_CYCLES) || (offset == OFF_WINDOW);
    assign wr_en     = psel & penable & pwrite;
    assign wr_base   = wr_en & (offset == OFF_BASE);
    assign wr_ctrl   = wr_en & (offset == OFF_CTRL);
    assign wr_status = wr_en & (offset == OFF_STATUS);
    assign wr_window = wr_en & (offset == OFF_WINDOW);
    assign abort_req = wr_ctrl & pwdata[1];
    assign start_req = wr_ctrl & pwdata[0] & ~pwdata[1];

    assign window_hit = (window_q != '0) &&
                        ((raw_arvalid && (raw_araddr >= window_q)) ||
                         (raw_awvalid && (raw_awaddr >= window_q)));

    assign m_axi_araddr = raw_araddr + base_q;
    assign m_axi_awaddr = raw_awaddr + base_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ctr_q      <= '0;
            cycles_q   <= '0;
            base_q     <= '0;
            window_q   <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            cycles_q   <= cycles_d;
            base_q     <= base_d;
            window_q   <= window_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        cycles_d   = cycles_q;
        base_d     = wr_base   ? pwdata[AXI_ADDR_WIDTH-1:0] : base_q;
        window_d   = wr_window ? pwdata[AXI_ADDR_WIDTH-1:0] : window_q;
        irq_en_d   = wr_ctrl   ? pwdata[2] : irq_en_q;
        done_d     = (wr_status && pwdata[1]) ? 1'b0 : done_q;
        addr_err_d = (wr_status && pwdata[2]) ? 1'b0 : addr_err_q;

        case (state_q)
            ST_IDLE: begin
                ctr_d = '0;
                if (start_req) begin
                    state_d  = ST_RESET;
                    cycles_d = '0;
                    done_d   = 1'b0;
                end
            end
            ST_RESET: begin
                if (abort_req) begin
                    state_d = ST_IDLE;
                    ctr_d   = '0;
                end else if (ctr_q == RD_LAST) begin
                    state_d = ST_RUN;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + 32'd1;
                end
            end
            ST_RUN: begin
                if (window_hit) addr_err_d = 1'b1;
                if (abort_req) begin
                    state_d = ST_IDLE;
                    ctr_d   = '0;
                end else if ((ctr_q == GRACE) && !core_busy) begin
                    // Completion cycle is not counted, so CYCLES equals the busy span.
                    state_d = ST_IDLE;
                    ctr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    if (cycles_q != '1) cycles_d = cycles_q + CNT_WIDTH'(1);
                    if (ctr_q != GRACE) ctr_d = ctr_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ctr_d   = '0;
            end
        endcase
    end

    always_comb begin
        base_rd   = '0;
        window_rd = '0;
        cycles_rd = '0;
        base_rd[AXI_ADDR_WIDTH-1:0]   = base_q;
        window_rd[AXI_ADDR_WIDTH-1:0] = window_q;
        cycles_rd[CNT_WIDTH-1:0]      = cycles_q;
        rd_data = '0;
        if (psel && !pwrite) begin
            case (offset)
                OFF_BASE:   rd_data = base_rd;
                OFF_CTRL:   rd_data = {29'd0, irq_en_q, 2'b00};
                OFF_STATUS: rd_data = {27'd0, state_q, addr_err_q, done_q, core_busy};
                OFF_CYCLES: rd_data = cycles_rd;
                OFF_WINDOW: rd_data = window_rd;
                default:    rd_data = '0;
            endcase
        end
    end

    // Outputs are forced to their safe values while reset is held, before any clock edge.
    assign prdata      = reset ? rd_data : 32'd0;
    assign pready      = 1'b1;
    assign pslverr     = reset & psel & penable & ~mapped;
    assign core_clk_en = reset & (state_q != ST_IDLE);
    assign core_reset  = ~reset | (state_q != ST_RUN);
    assign irq         = reset & done_q & irq_en_q;

endmodule

// File: tb/tb_vx_run_ctrl.sv
// Directed bench for vx_run_ctrl: a register-access vector table plus hand-written
// sequences for the run, interrupt, relocation, window and abort behaviour.
module tb_vx_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic        core_busy, core_clk_en, core_reset;
    logic [31:0] raw_araddr, raw_awaddr, m_axi_araddr, m_axi_awaddr;
    logic        raw_arvalid, raw_awvalid, irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vx_run_ctrl dut (
        .clk(clk), .reset(reset),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr),
        .core_busy(core_busy), .core_clk_en(core_clk_en), .core_reset(core_reset),
        .raw_araddr(raw_araddr), .raw_awaddr(raw_awaddr),
        .raw_arvalid(raw_arvalid), .raw_awvalid(raw_awvalid),
        .m_axi_araddr(m_axi_araddr), .m_axi_awaddr(m_axi_awaddr),
        .irq(irq)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  off;
        logic [31:0] data;
        logic        busy;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] off, input logic [31:0] d, output logic err);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = {24'd0, off}; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1 err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] off, output logic [31:0] d, output logic err);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = {24'd0, off};
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cnt;

    initial begin
        vecs[0]  = '{1'b0, 8'h58, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 8'h5C, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 8'h54, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 8'h50, 32'h12345678, 1'b0, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 8'h50, 32'h0,        1'b0, 32'h12345678, 1'b0};
        vecs[5]  = '{1'b1, 8'h60, 32'h0000ABCD, 1'b0, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 8'h60, 32'h0,        1'b0, 32'h0000ABCD, 1'b0};
        vecs[7]  = '{1'b1, 8'h54, 32'h7,        1'b0, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 8'h54, 32'h0,        1'b0, 32'h4,        1'b0};
        vecs[9]  = '{1'b0, 8'h58, 32'h0,        1'b1, 32'h1,        1'b0};
        vecs[10] = '{1'b1, 8'h44, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 8'h44, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 8'h50, 32'h0,        1'b0, 32'h12345678, 1'b0};
        vecs[13] = '{1'b1, 8'h5C, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 8'h5C, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[15] = '{1'b1, 8'h54, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[16] = '{1'b0, 8'h54, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[17] = '{1'b1, 8'h60, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[18] = '{1'b0, 8'h60, 32'h0,        1'b0, 32'h0,        1'b0};

        reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; core_busy = 1'b0;
        raw_araddr = 32'h0; raw_awaddr = 32'h0; raw_arvalid = 1'b0; raw_awvalid = 1'b0;

        // Reset: outputs safe, and an unmapped access during reset raises no error.
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; paddr = 32'h44;
        #1;
        check("rst_pslverr", {31'd0, pslverr}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        check("rst_core_reset", {31'd0, core_reset}, 32'h1);
        check("rst_core_clk_en", {31'd0, core_clk_en}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("pready", {31'd0, pready}, 32'h1);
        reset = 1'b1;

        // Register-access vectors, all in IDLE.
        for (int i = 0; i < 19; i++) begin
            core_busy = vecs[i].busy;
            if (vecs[i].wr) begin
                apb_write(vecs[i].off, vecs[i].data, er);
                check($sformatf("vec%0d_wr_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            end else begin
                apb_read(vecs[i].off, rd, er);
                check($sformatf("vec%0d_rd_data", i), rd, vecs[i].exp_rd);
                check($sformatf("vec%0d_rd_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            end
        end
        core_busy = 1'b0;

        // prdata is zero when not selected.
        @(negedge clk);
        paddr = 32'h50; pwrite = 1'b0;
        #1 check("prdata_idle_bus", prdata, 32'h0);

        // Full run: 8 reset cycles, 20 busy run cycles, then completion.
        apb_write(8'h50, 32'h8000_0000, er);
        raw_araddr = 32'h0000_1234;
        #1 check("reloc_base_8000", m_axi_araddr, 32'h8000_1234);
        core_busy = 1'b1;
        apb_write(8'h54, 32'h1, er);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (core_reset && core_clk_en) cnt++;
            @(negedge clk);
        end
        check("reset_hold_cycles", cnt, 32'd8);
        check("run_core_reset", {31'd0, core_reset}, 32'h0);
        check("run_core_clk_en", {31'd0, core_clk_en}, 32'h1);
        repeat (20) @(negedge clk);
        check("run_still_active", {31'd0, core_reset}, 32'h0);
        core_busy = 1'b0;
        @(negedge clk);
        check("done_core_reset", {31'd0, core_reset}, 32'h1);
        check("done_core_clk_en", {31'd0, core_clk_en}, 32'h0);
        apb_read(8'h58, rd, er);
        check("status_done", rd, 32'h2);
        apb_read(8'h5C, rd, er);
        check("cycles_20", rd, 32'd20);
        check("irq_masked", {31'd0, irq}, 32'h0);

        // Interrupt enable, W1C, restart clears CYCLES.
        apb_write(8'h54, 32'h4, er);
        check("irq_set", {31'd0, irq}, 32'h1);
        apb_write(8'h58, 32'h2, er);
        check("irq_cleared", {31'd0, irq}, 32'h0);
        apb_read(8'h58, rd, er);
        check("status_after_w1c", rd, 32'h0);
        apb_write(8'h54, 32'h5, er);
        apb_read(8'h5C, rd, er);
        check("cycles_cleared", rd, 32'h0);
        repeat (5) @(negedge clk);

        // busy low from RUN entry: entry cycle plus BUSY_GRACE ticks, CYCLES = BUSY_GRACE.
        cnt = 0;
        while (!core_reset && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("grace_window", cnt, 32'd5);
        apb_read(8'h5C, rd, er);
        check("cycles_grace", rd, 32'd4);
        check("irq_after_grace", {31'd0, irq}, 32'h1);

        // Relocation wrap and window violation.
        apb_write(8'h50, 32'hFFFF_FFF0, er);
        raw_araddr = 32'h20; raw_awaddr = 32'h1000;
        #1 check("reloc_wrap_ar", m_axi_araddr, 32'h10);
        check("reloc_wrap_aw", m_axi_awaddr, 32'h0000_0FF0);
        apb_write(8'h60, 32'h1000, er);
        core_busy = 1'b1;
        apb_write(8'h54, 32'h5, er);
        repeat (8) @(negedge clk);
        raw_arvalid = 1'b1; raw_araddr = 32'hFFF;
        @(negedge clk);
        raw_arvalid = 1'b0;
        apb_read(8'h58, rd, er);
        check("in_window_no_err", rd, 32'h11);
        raw_awvalid = 1'b1; raw_awaddr = 32'h1000;
        @(negedge clk);
        raw_awvalid = 1'b0;
        apb_read(8'h58, rd, er);
        check("addr_err_set", rd, 32'h15);
        apb_write(8'h58, 32'h4, er);
        apb_read(8'h58, rd, er);
        check("addr_err_w1c", rd, 32'h11);

        // Abort mid-run, then START+ABORT in IDLE.
        apb_write(8'h54, 32'h6, er);
        check("abort_core_reset", {31'd0, core_reset}, 32'h1);
        check("abort_core_clk_en", {31'd0, core_clk_en}, 32'h0);
        apb_read(8'h58, rd, er);
        check("abort_status", rd, 32'h1);
        check("abort_irq", {31'd0, irq}, 32'h0);
        apb_write(8'h54, 32'h7, er);
        check("start_abort_core_reset", {31'd0, core_reset}, 32'h1);
        apb_read(8'h58, rd, er);
        check("start_abort_status", rd, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
